// File: rtl/tap_bank_pkg.sv
// rtl/tap_bank_pkg.sv - shared constants and control bundle for the neural tap bank
package tap_bank_pkg;

  localparam int TAP_LANES  = 6;
  localparam int TAP_DATA_W = 32;
  localparam int TAP_ADDR_W = 5;
  localparam int TAP_SEL_W  = $clog2(TAP_LANES);

  // One cycle of tap-bank control, as a layer controller would drive it.
  typedef struct packed {
    logic                  wr_vld;
    logic [TAP_ADDR_W-1:0] wr_address;
    logic                  sub_vld;
    logic [TAP_SEL_W-1:0]  sub_addr;
    logic [TAP_DATA_W-1:0] sub_data;
    logic                  rd_vld;
    logic [TAP_ADDR_W-1:0] rd_address;
    logic                  inter;
    logic                  inter_first;
  } tap_bank_ctrl_t;

endpackage

// File: rtl/tap_bank_lane_mem.sv
// rtl/tap_bank_lane_mem.sv - one 1R1W tap RAM lane with registered read
// Ports:
//   clk, reset      clock, synchronous active-high reset (clears rdata only)
//   we/waddr/wdata  write port, commits at the clock edge
//   re/raddr        read port; rdata updates one cycle later and holds when re=0
//   rdata           registered read data (old contents on same-address write)
module tap_bank_lane_mem
  import tap_bank_pkg::*;
#(
  parameter int DATA_W = TAP_DATA_W,
  parameter int ADDR_W = TAP_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Array has no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/neural_tap_bank.sv
// rtl/neural_tap_bank.sv - banked tap-weight memory with linear and rotating reads
// Optional build macro: TAP_BANK_BYPASS_EN (same-cycle write data forwarded to read).
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   wr_vld, wr_address, wr_data     full-width write, lane i at [i*DATA_W +: DATA_W]
//   sub_vld, sub_addr, sub_data     single-lane write at wr_address, overrides wr_vld
//   rd_vld, rd_address              read strobe and linear read address
//   inter, inter_first              rotating read advance / start of rotating sequence
//   rd_data, rd_data_vld            registered read data and its valid
//   sub_err                         pulse one cycle after a sub write to a missing lane
module neural_tap_bank
  import tap_bank_pkg::*;
#(
  parameter int LANES  = TAP_LANES,
  parameter int DATA_W = TAP_DATA_W,
  parameter int ADDR_W = TAP_ADDR_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_vld,
  input  logic [ADDR_W-1:0]         wr_address,
  input  logic [LANES*DATA_W-1:0]   wr_data,
  input  logic                      sub_vld,
  input  logic [$clog2(LANES)-1:0]  sub_addr,
  input  logic [DATA_W-1:0]         sub_data,
  input  logic                      rd_vld,
  input  logic [ADDR_W-1:0]         rd_address,
  input  logic                      inter,
  input  logic                      inter_first,
  output logic [LANES*DATA_W-1:0]   rd_data,
  output logic                      rd_data_vld,
  output logic                      sub_err
);

  localparam int SEL_W = $clog2(LANES);

  logic [SEL_W-1:0]  cnt;
  logic [ADDR_W-1:0] base;
  logic              rotate;
  logic              cnt_last;
  logic              sub_bad;

  // The inter_first cycle still reads rd_address; rotation starts on the next one.
  assign rotate   = inter & ~inter_first;
  assign cnt_last = (32'(cnt) == 32'(LANES - 1));
  assign sub_bad  = sub_vld & (32'(sub_addr) >= 32'(LANES));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      base <= '0;
    end else if (inter) begin
      if (inter_first) begin
        cnt  <= '0;
        base <= '0;
      end else if (cnt_last) begin
        cnt  <= '0;
        base <= base + ADDR_W'(LANES);
      end else begin
        cnt  <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_vld <= 1'b0;
      sub_err     <= 1'b0;
    end else begin
      rd_data_vld <= rd_vld;
      sub_err     <= sub_bad;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic              we;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] q;
    logic [31:0]       rot;

    // Sub writes override full-width writes; nothing commits during reset.
    assign we    = ~reset & (sub_vld ? (sub_addr == SEL_W'(i)) : wr_vld);
    assign wdata = sub_vld ? sub_data : wr_data[i*DATA_W +: DATA_W];

    // cnt and i are both below LANES, so one conditional subtract is the modulo.
    always_comb begin
      rot = 32'(cnt) + 32'(i);
      if (rot >= 32'(LANES)) rot = rot - 32'(LANES);
      raddr = rotate ? ADDR_W'(rot + 32'(base)) : rd_address;
    end

    tap_bank_lane_mem #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_mem (
      .clk   (clk),
      .reset (reset),
      .we    (we),
      .waddr (wr_address),
      .wdata (wdata),
      .re    (rd_vld),
      .raddr (raddr),
      .rdata (q)
    );

`ifdef TAP_BANK_BYPASS_EN
    logic              byp_q;
    logic [DATA_W-1:0] byp_data_q;

    // Remember whether this read collided with a write, and capture that write.
    always_ff @(posedge clk) begin
      if (reset) begin
        byp_q <= 1'b0;
      end else if (rd_vld) begin
        byp_q      <= we & (raddr == wr_address);
        byp_data_q <= wdata;
      end
    end

    assign rd_data[i*DATA_W +: DATA_W] = byp_q ? byp_data_q : q;
`else
    assign rd_data[i*DATA_W +: DATA_W] = q;
`endif
  end

endmodule

// File: tb/tb_neural_tap_bank.sv
// tb/tb_neural_tap_bank.sv - randomized self-checking bench for neural_tap_bank
module tb_neural_tap_bank;

  localparam int LANES  = 6;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;
  localparam int BUS_W  = LANES * DATA_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_vld;
  logic [ADDR_W-1:0] wr_address;
  logic [BUS_W-1:0]  wr_data;
  logic              sub_vld;
  logic [2:0]        sub_addr;
  logic [DATA_W-1:0] sub_data;
  logic              rd_vld;
  logic [ADDR_W-1:0] rd_address;
  logic              inter;
  logic              inter_first;
  logic [BUS_W-1:0]  rd_data;
  logic              rd_data_vld;
  logic              sub_err;

  neural_tap_bank #(
    .LANES  (LANES),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_vld      (wr_vld),
    .wr_address  (wr_address),
    .wr_data     (wr_data),
    .sub_vld     (sub_vld),
    .sub_addr    (sub_addr),
    .sub_data    (sub_data),
    .rd_vld      (rd_vld),
    .rd_address  (rd_address),
    .inter       (inter),
    .inter_first (inter_first),
    .rd_data     (rd_data),
    .rd_data_vld (rd_data_vld),
    .sub_err     (sub_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [DATA_W-1:0] mem_m [LANES][DEPTH];
  int                cnt_m;
  int                base_m;
  logic [BUS_W-1:0]  exp_rd;
  logic              exp_vld;
  logic              exp_err;

  task automatic check(input string tag, input logic [BUS_W-1:0] got, input logic [BUS_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] init_val(input int a, input int l);
    return 32'h1000_0000 + 32'(a * 16 + l);
  endfunction

  task automatic idle();
    reset = 1'b0; wr_vld = 1'b0; wr_address = '0; wr_data = '0;
    sub_vld = 1'b0; sub_addr = '0; sub_data = '0;
    rd_vld = 1'b0; rd_address = '0; inter = 1'b0; inter_first = 1'b0;
  endtask

  // One clock: advance the reference model from the inputs seen at the edge,
  // then compare every output shortly after the edge.
  task automatic cyc();
    logic [BUS_W-1:0] nrd;
    int a;
    bit hit;
    @(posedge clk);
    if (reset) begin
      exp_rd = '0; exp_vld = 1'b0; exp_err = 1'b0; cnt_m = 0; base_m = 0;
    end else begin
      nrd = exp_rd;
      if (rd_vld) begin
        for (int l = 0; l < LANES; l++) begin
          if (inter && !inter_first) a = (((cnt_m + l) % LANES) + base_m) % DEPTH;
          else                       a = int'(rd_address);
          nrd[l*DATA_W +: DATA_W] = mem_m[l][a];
`ifdef TAP_BANK_BYPASS_EN
          hit = sub_vld ? (int'(sub_addr) == l) : wr_vld;
          if (hit && a == int'(wr_address))
            nrd[l*DATA_W +: DATA_W] = sub_vld ? sub_data : wr_data[l*DATA_W +: DATA_W];
`endif
        end
      end
      exp_rd  = nrd;
      exp_vld = rd_vld;
      exp_err = sub_vld && (int'(sub_addr) >= LANES);
      if (sub_vld) begin
        if (int'(sub_addr) < LANES) mem_m[sub_addr][wr_address] = sub_data;
      end else if (wr_vld) begin
        for (int l = 0; l < LANES; l++) mem_m[l][wr_address] = wr_data[l*DATA_W +: DATA_W];
      end
      if (inter) begin
        if (inter_first) begin
          cnt_m = 0; base_m = 0;
        end else if (cnt_m == LANES - 1) begin
          cnt_m = 0; base_m = (base_m + LANES) % DEPTH;
        end else begin
          cnt_m++;
        end
      end
    end
    #1;
    check("rd_data", rd_data, exp_rd);
    check("rd_data_vld", BUS_W'(rd_data_vld), BUS_W'(exp_vld));
    check("sub_err", BUS_W'(sub_err), BUS_W'(exp_err));
  endtask

  int l0_addr [7] = '{0, 1, 2, 3, 4, 5, 6};
  int l5_addr [7] = '{5, 0, 1, 2, 3, 4, 11};
  logic [BUS_W-1:0] row;

  initial begin
    idle();
    exp_rd = '0; exp_vld = 1'b0; exp_err = 1'b0; cnt_m = 0; base_m = 0;
    reset = 1'b1;
    cyc();
    cyc();
    check("reset_rd_data", rd_data, '0);
    check("reset_vld", BUS_W'(rd_data_vld), '0);
    idle();

    // Fill every address with a recognisable pattern.
    for (int a = 0; a < DEPTH; a++) begin
      wr_vld = 1'b1; wr_address = ADDR_W'(a);
      for (int l = 0; l < LANES; l++) wr_data[l*DATA_W +: DATA_W] = init_val(a, l);
      cyc();
    end
    idle();
    rd_vld = 1'b1; rd_address = 5'd7;
    cyc();
    check("linear_a7_l3", BUS_W'(rd_data[3*DATA_W +: DATA_W]), BUS_W'(32'h1000_0073));
    check("linear_vld", BUS_W'(rd_data_vld), BUS_W'(1'b1));

    // Sub write overrides a simultaneous full-width write.
    idle();
    sub_vld = 1'b1; sub_addr = 3'd2; sub_data = 32'hDEAD_BEEF;
    wr_address = 5'd4; wr_vld = 1'b1; wr_data = '1;
    cyc();
    idle(); rd_vld = 1'b1; rd_address = 5'd4;
    cyc();
    check("sub_l2", BUS_W'(rd_data[2*DATA_W +: DATA_W]), BUS_W'(32'hDEAD_BEEF));
    check("sub_l1_kept", BUS_W'(rd_data[1*DATA_W +: DATA_W]), BUS_W'(init_val(4, 1)));

    // Sub write to a lane that does not exist.
    idle(); sub_vld = 1'b1; sub_addr = 3'd6; sub_data = 32'h0BAD_0BAD; wr_address = 5'd5;
    cyc();
    check("sub_err_pulse", BUS_W'(sub_err), BUS_W'(1'b1));
    idle(); rd_vld = 1'b1; rd_address = 5'd5;
    cyc();
    check("sub_err_clear", BUS_W'(sub_err), '0);
    for (int l = 0; l < LANES; l++) row[l*DATA_W +: DATA_W] = init_val(5, l);
    check("sub_bad_nowrite", rd_data, row);

    // Rotating reads.
    idle(); inter = 1'b1; inter_first = 1'b1; rd_vld = 1'b1;
    cyc();
    inter_first = 1'b0;
    for (int k = 0; k < 7; k++) begin
      cyc();
      check("inter_l0", BUS_W'(rd_data[0 +: DATA_W]), BUS_W'(init_val(l0_addr[k], 0)));
      check("inter_l5", BUS_W'(rd_data[5*DATA_W +: DATA_W]), BUS_W'(init_val(l5_addr[k], 5)));
    end

    // Base wrap-around past the top of the lane.
    inter_first = 1'b1;
    cyc();
    inter_first = 1'b0;
    for (int k = 0; k < 32; k++) cyc();
    check("wrap_l4", BUS_W'(rd_data[4*DATA_W +: DATA_W]), BUS_W'(init_val(3, 4)));

    // Same-cycle read/write collision.
    idle(); sub_vld = 1'b1; sub_addr = 3'd0; sub_data = 32'h5555_5555; wr_address = 5'd9;
    cyc();
    sub_data = 32'hAAAA_AAAA; rd_vld = 1'b1; rd_address = 5'd9;
    cyc();
`ifdef TAP_BANK_BYPASS_EN
    check("collision_l0", BUS_W'(rd_data[0 +: DATA_W]), BUS_W'(32'hAAAA_AAAA));
`else
    check("collision_l0", BUS_W'(rd_data[0 +: DATA_W]), BUS_W'(32'h5555_5555));
`endif

    // Reset in the middle of a rotating sequence with cnt=3.
    idle(); inter = 1'b1; inter_first = 1'b1; rd_vld = 1'b1;
    cyc();
    inter_first = 1'b0;
    for (int k = 0; k < 3; k++) cyc();
    reset = 1'b1; wr_vld = 1'b1; wr_address = 5'd2; wr_data = '1;
    cyc();
    check("midrst_rd_data", rd_data, '0);
    check("midrst_vld", BUS_W'(rd_data_vld), '0);
    reset = 1'b0; wr_vld = 1'b0;
    cyc();
    check("midrst_l2_cnt0", BUS_W'(rd_data[2*DATA_W +: DATA_W]), BUS_W'(init_val(2, 2)));

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      idle();
      reset       = ($urandom_range(0, 99) < 2);
      inter       = ($urandom_range(0, 2) != 0);
      inter_first = inter && ($urandom_range(0, 9) == 0);
      rd_vld      = inter ? 1'b1 : 1'($urandom_range(0, 1));
      wr_vld      = 1'($urandom_range(0, 1));
      wr_address  = ADDR_W'($urandom_range(0, DEPTH - 1));
      rd_address  = ($urandom_range(0, 3) == 0) ? wr_address : ADDR_W'($urandom_range(0, DEPTH - 1));
      for (int l = 0; l < LANES; l++) wr_data[l*DATA_W +: DATA_W] = $urandom;
      sub_vld     = ($urandom_range(0, 4) == 0);
      sub_addr    = 3'($urandom_range(0, 7));
      sub_data    = $urandom;
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
